immgen_stage: RTL and testbench
===============================

Name: immgen_stage

Overview:
Registered, handshaked immediate-generation stage for the RV32I/RV64I decode path. It accepts one instruction word plus PC per transfer and classifies the format (R/I/S/B/U/J/illegal). It produces the sign- or zero-extended immediate at DATA_WIDTH and, for B/J formats, the PC-relative target. A two-entry skid buffer decouples upstream fetch from downstream execute so in_ready is a pure register output.

Parameters:
DATA_WIDTH, 32, immediate/PC/target width; legal values 32 or 64.
SHAMT_W, (DATA_WIDTH==64 ? 6 : 5), shift-amount field width for OP-IMM shifts.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  instruction/PC presented
in_ready  output  1  stage can accept this cycle (registered)
in_inst  input  32  instruction word
in_pc  input  DATA_WIDTH  PC of in_inst
out_valid  output  1  result presented
out_ready  input  1  downstream accepts
out_imm  output  DATA_WIDTH  extended immediate
out_fmt  output  3  0=R,1=I,2=S,3=B,4=U,5=J,7=ILLEGAL
out_target  output  DATA_WIDTH  in_pc+imm for B/J, else 0
out_pc  output  DATA_WIDTH  PC passthrough

Behaviour:
- Reset (rst_n=0, async): both entries invalid. out_valid=0, in_ready=1, out_imm/out_target/out_pc=0, out_fmt=0. Mid-transfer reset drops all data.
- Decode on opcode in_inst[6:0]:
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111. R: 0110011.
  - Any other opcode gives ILLEGAL with imm=0.
- Immediate construction, sign bit inst[31] replicated to DATA_WIDTH:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}, sign-extended above bit 31 when DATA_WIDTH=64.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R: 0.
- OP-IMM shift exception: opcode 0010011 with funct3 001/101 gives imm = zero-extended inst[20+SHAMT_W-1:20]; fmt stays I.
- Target: out_target = pc + imm modulo 2^DATA_WIDTH (wrap-around, no flag) for fmt B/J; 0 otherwise.
- Decode and add are computed on the input side and registered. Latency is exactly 1 cycle from accepted input to out_valid when the buffer is empty.
- Handshake: transfer in when in_valid&in_ready; transfer out when out_valid&out_ready. out_* hold stable while out_valid&!out_ready. Strict FIFO order, no loss, no duplication.
- Buffer: main entry drives outputs; skid entry catches a word accepted while main is stalled.
  - in_ready = !skid_valid (registered).
  - On a main pop with skid valid, skid moves to main the same edge.
  - Simultaneous push and pop with one entry held: the new word goes to main, and skid stays empty.
  - Full (2 entries) means in_ready=0 next cycle.
  - Sustained throughput is 1 transfer/cycle when out_ready=1.
- Flush: next edge both entries are invalid, out_valid=0, in_ready=1. An input presented in the flush cycle is discarded. Flush has priority over push and pop.
- Illegal instructions flow through the handshake like any other; no stall, no exception state.

Test Plan:
- Reset then in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_target=0.
- 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt=2. Then 0x01F09093 (slli x1,x1,31) -> out_imm=0x0000001F, fmt=1.
- 0xFE000CE3 (beq -8), pc=0x100 -> imm=0xFFFFFFF8, fmt=3, target=0xF8. Then 0x001000EF (jal +0x800), pc=0x100 -> imm=0x800, fmt=5, target=0x900.
- 0x123450B7 (lui) -> imm=0x12345000, fmt=4. 0x0000007F -> fmt=7, imm=0. DATA_WIDTH=64: 0x800000B7 -> imm=0xFFFFFFFF80000000.
- Stream 4 words with out_ready=0 for 3 cycles -> 2 accepted, in_ready=0 after second. Release gives all 4 out in order, one per cycle, none lost.
- Two entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle word never appears. Async rst_n pulse mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage: decodes the RV32I/RV64I format, builds the
// extended immediate and B/J branch target, and buffers results in a two-entry skid buffer.
module immgen_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = (DATA_WIDTH == 64) ? 6 : 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [2:0]            out_fmt,
    output logic [DATA_WIDTH-1:0] out_target,
    output logic [DATA_WIDTH-1:0] out_pc
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            fmt;
        logic [DATA_WIDTH-1:0] target;
        logic [DATA_WIDTH-1:0] pc;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sign;
    logic [31:0] imm32;
    entry_t      dec;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign sign   = in_inst[31];

    always_comb begin
        imm32   = '0;
        dec     = '0;
        dec.fmt = FMT_ILL;
        dec.pc  = in_pc;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                dec.fmt = FMT_I;
                imm32   = {{20{sign}}, in_inst[31:20]};
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                imm32   = {{20{sign}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                imm32   = {{19{sign}}, sign, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                imm32   = {in_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                imm32   = {{11{sign}}, sign, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_REG: dec.fmt = FMT_R;
            default: ;
        endcase
        dec.imm = DATA_WIDTH'($signed(imm32));
        // SLLI/SRLI/SRAI carry a shift amount, not a signed immediate; funct7 bits are dropped
        if (opcode == OP_IMM && funct3[1:0] == 2'b01) begin
            dec.imm = DATA_WIDTH'(in_inst[20 +: SHAMT_W]);
        end
        if (dec.fmt == FMT_B || dec.fmt == FMT_J) begin
            dec.target = in_pc + dec.imm;
        end
    end

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   push, pop;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        push         = in_valid && !skid_valid_q;
        pop          = main_valid_q && out_ready;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            // skid is only ever full while in_ready is low, so no push can race it here
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            if (main_valid_q) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready   = !skid_valid_q;
    assign out_valid  = main_valid_q;
    assign out_imm    = main_q.imm;
    assign out_fmt    = main_q.fmt;
    assign out_target = main_q.target;
    assign out_pc     = main_q.pc;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: directed vectors, then randomized traffic scored against
// an arithmetic reference decoder and an occupancy/order queue model.
module tb_immgen_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;

    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
    logic [31:0] in_inst64;
    logic [63:0] in_pc64, out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic [31:0] pc;
    } exp_t;
    exp_t q[$];

    immgen_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_target(out_target), .out_pc(out_pc)
    );

    immgen_stage #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_target(out_target64), .out_pc(out_pc64)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint val, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (val >= half) ? val - 2 * half : val;
    endfunction

    // Reference decoder: field values treated as integers, then wrapped to dw bits
    function automatic void ref_dec(input logic [31:0] i, input logic [63:0] pc, input int dw,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic [63:0] tgt);
        longint      v = 0;
        logic [63:0] mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        fmt = 3'd7;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                fmt = 3'd1;
                v = sx(longint'(i[31:20]), 12);
                if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
                    v = (dw == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
            end
            7'h23: begin fmt = 3'd2; v = sx(longint'({i[31:25], i[11:7]}), 12); end
            7'h63: begin fmt = 3'd3; v = 2 * sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12); end
            7'h37, 7'h17: begin fmt = 3'd4; v = 4096 * sx(longint'(i[31:12]), 20); end
            7'h6F: begin fmt = 3'd5; v = 2 * sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20); end
            7'h33: fmt = 3'd0;
            default: ;
        endcase
        imm = 64'(v) & mask;
        tgt = (fmt == 3'd3 || fmt == 3'd5) ? ((pc + 64'(v)) & mask) : 64'd0;
    endfunction

    // One clock of traffic: drive at negedge, compare against the model, update model at posedge
    task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic orr, input logic fl, output logic acc);
        logic [63:0] ei, et;
        logic [2:0]  ef;
        logic        fire_out;
        exp_t        e;
        @(negedge clk);
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = orr; flush = fl;
        #1;
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_imm", 64'(out_imm), 64'(q[0].imm));
            chk("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
            chk("out_target", 64'(out_target), 64'(q[0].tgt));
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
        end
        acc      = iv && in_ready && !fl;
        fire_out = orr && (q.size() > 0);
        ref_dec(inst, {32'd0, pc}, 32, ei, ef, et);
        e.imm = ei[31:0]; e.fmt = ef; e.tgt = et[31:0]; e.pc = pc;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (fire_out) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic direct(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] ei, input logic [2:0] ef, input logic [31:0] et);
        @(negedge clk);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, 64'(out_imm), 64'(ei));
        chk({tag, "_fmt"}, 64'(out_fmt), 64'(ef));
        chk({tag, "_target"}, 64'(out_target), 64'(et));
        chk({tag, "_pc"}, 64'(out_pc), 64'(pc));
    endtask

    task automatic direct64(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                            input logic [63:0] ei, input logic [2:0] ef, input logic [63:0] et);
        @(negedge clk);
        in_valid64 = 1'b1; in_inst64 = inst; in_pc64 = pc;
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        chk({tag, "_valid"}, 64'(out_valid64), 64'd1);
        chk({tag, "_imm"}, out_imm64, ei);
        chk({tag, "_fmt"}, 64'(out_fmt64), 64'(ef));
        chk({tag, "_target"}, out_target64, et);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
        logic [31:0] r = $urandom();
        logic [6:0]  op = ops[$urandom_range(0, 11)];
        if (op == 7'h00) op = r[6:0];
        return {r[31:7], op};
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r = $urandom();
        if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] w[4];
        int          idx, n, guard;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; in_inst64 = '0; in_pc64 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_fmt", 64'(out_fmt), 64'd0);
        chk("rst_out_target", 64'(out_target), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        direct("addi", 32'hFFF0_0093, 32'h0000_0040, 32'hFFFF_FFFF, 3'd1, 32'h0);
        direct("sw",   32'hFE11_2E23, 32'h0000_0044, 32'hFFFF_FFFC, 3'd2, 32'h0);
        direct("slli", 32'h01F0_9093, 32'h0000_0048, 32'h0000_001F, 3'd1, 32'h0);
        direct("beq",  32'hFE00_0CE3, 32'h0000_0100, 32'hFFFF_FFF8, 3'd3, 32'h0000_00F8);
        direct("jal",  32'h0010_00EF, 32'h0000_0100, 32'h0000_0800, 3'd5, 32'h0000_0900);
        direct("lui",  32'h1234_50B7, 32'h0000_0104, 32'h1234_5000, 3'd4, 32'h0);
        direct("ill",  32'h0000_007F, 32'h0000_0108, 32'h0000_0000, 3'd7, 32'h0);
        direct("add",  32'h0020_80B3, 32'h0000_010C, 32'h0000_0000, 3'd0, 32'h0);
        direct("beq_wrap", 32'h0000_0463, 32'hFFFF_FFFC, 32'h0000_0008, 3'd3, 32'h0000_0004);

        direct64("lui64",  32'h8000_00B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'h0);
        direct64("slli64", 32'h03F0_9093, 64'h0, 64'h0000_0000_0000_003F, 3'd1, 64'h0);
        direct64("beq64",  32'hFE00_0CE3, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3,
                 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);

        // Let the directed results drain, then the model starts from empty
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Stall: 4 words offered, only two fit
        for (int k = 0; k < 4; k++) w[k] = rand_inst();
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, w[idx], 32'h200 + 32'(4 * idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_accepts", 64'(idx), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        guard = 0;
        while ((idx < 4 || q.size() > 0) && guard < 20) begin
            cycle(idx < 4, w[idx % 4], 32'h200 + 32'(4 * idx), 1'b1, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        chk("stream_drained", 64'(idx == 4 && q.size() == 0), 64'd1);

        // Fill both entries, then flush with a word on the input
        for (int c = 0; c < 2; c++) cycle(1'b1, rand_inst(), rand_pc(), 1'b0, 1'b0, acc);
        chk("full_before_flush", 64'(q.size()), 64'd2);
        cycle(1'b1, 32'h0000_0013, 32'hDEAD_BEE0, 1'b0, 1'b1, acc);
        for (int c = 0; c < 3; c++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Sustained throughput and random back-pressure with occasional flushes
        for (int c = 0; c < 40; c++) cycle(1'b1, rand_inst(), rand_pc(), 1'b1, 1'b0, acc);
        n = 0;
        for (int c = 0; c < 600; c++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), rand_pc(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, acc);
            if (acc) n++;
        end
        chk("random_progress", 64'(n > 100), 64'd1);

        // Async reset with data in flight
        for (int c = 0; c < 2; c++) cycle(1'b1, rand_inst(), rand_pc(), 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_imm", 64'(out_imm), 64'd0);
        chk("arst_out_target", 64'(out_target), 64'd0);
        chk("arst_out_pc", 64'(out_pc), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++)
            cycle($urandom_range(0, 1) != 0, rand_inst(), rand_pc(), $urandom_range(0, 1) != 0,
                  1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
